hex_word_parser: RTL and testbench

- Sequencing controller around the hex-character decode stage (ASCII '0'-'9', 'a'-'f' to nibble).
- Consumes a byte-serial character stream, one character per accepted cycle.
- Recognises tokens of the form "0x<hex digits>;" and assembles the digits MSB-first into a word.
- Emits a one-cycle result strobe per good token, or an error strobe per bad token, then resynchronises.

---
 rtl/hex_word_parser.sv | 130 +++++++++++++
 tb/tb_hex_word_parser.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/hex_word_parser.sv
// Byte-serial parser for "0x<hex digits>;" tokens. Hex digits are assembled
// MSB-first into a word. Each good token produces a one-cycle word_valid
// strobe. Each bad token produces a one-cycle err strobe, after which the
// parser resynchronises on the next ';'.
module hex_word_parser #(
  parameter int unsigned MAX_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              char,
  input  logic                    char_valid,
  output logic [4*MAX_DIGITS-1:0] word,
  output logic                    word_valid,
  output logic [3:0]              digits,
  output logic                    err,
  output logic                    busy
);

  localparam int unsigned W = 4 * MAX_DIGITS;

  localparam logic [7:0] ChSemi = 8'h3b;
  localparam logic [7:0] ChZero = 8'h30;
  localparam logic [7:0] ChX    = 8'h78;

  typedef enum logic [2:0] {
    StIdle,
    StZero,
    StPfx,
    StDig,
    StErr
  } state_e;

  state_e         state;
  logic [W-1:0]   acc;
  logic [3:0]     cnt;
  logic           is_hex;
  logic [3:0]     nibble;

  // Classify the incoming byte: lowercase hex digits only.
  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (char >= 8'h30 && char <= 8'h39) begin
      is_hex = 1'b1;
      nibble = char[3:0];
    end else if (char >= 8'h61 && char <= 8'h66) begin
      is_hex = 1'b1;
      nibble = char[3:0] + 4'd9;  // 'a' has low nibble 1, maps to 10
    end
  end

  // Token FSM with registered strobes, result and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      acc        <= '0;
      cnt        <= 4'd0;
      word       <= '0;
      digits     <= 4'd0;
      word_valid <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      err        <= 1'b0;
      if (char_valid) begin
        unique case (state)
          StIdle: begin
            // Anything other than '0' is separator noise.
            if (char == ChZero) begin
              state <= StZero;
              busy  <= 1'b1;
            end
          end
          StZero: begin
            if (char == ChX) begin
              state <= StPfx;
              acc   <= '0;
              cnt   <= 4'd0;
            end else begin
              state <= StErr;
              err   <= 1'b1;
            end
          end
          StPfx: begin
            if (is_hex) begin
              state <= StDig;
              acc   <= W'(nibble);
              cnt   <= 4'd1;
            end else begin
              state <= StErr;
              err   <= 1'b1;
            end
          end
          StDig: begin
            if (is_hex) begin
              if (cnt < 4'(MAX_DIGITS)) begin
                acc <= (acc << 4) | W'(nibble);
                cnt <= cnt + 4'd1;
              end else begin
                state <= StErr;
                err   <= 1'b1;
              end
            end else if (char == ChSemi) begin
              state      <= StIdle;
              busy       <= 1'b0;
              word       <= acc;
              digits     <= cnt;
              word_valid <= 1'b1;
            end else begin
              state <= StErr;
              err   <= 1'b1;
            end
          end
          StErr: begin
            if (char == ChSemi) begin
              state <= StIdle;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hex_word_parser.sv
// Directed bench for hex_word_parser: inputs are driven on the falling edge,
// and outputs are observed on the falling edge.
module tb_hex_word_parser;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  char;
  logic        char_valid;
  logic [31:0] word;
  logic        word_valid;
  logic [3:0]  digits;
  logic        err;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int wv_pulses  = 0;
  int err_pulses = 0;

  hex_word_parser #(.MAX_DIGITS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .char       (char),
    .char_valid (char_valid),
    .word       (word),
    .word_valid (word_valid),
    .digits     (digits),
    .err        (err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Count strobe cycles so that pulse totals can be checked per scenario.
  always @(negedge clk) begin
    if (word_valid === 1'b1) wv_pulses++;
    if (err === 1'b1) err_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] c);
    @(negedge clk);
    char       = c;
    char_valid = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    char_valid = 1'b0;
    char       = 8'h00;
  endtask

  task automatic send(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      drive(s[i]);
      for (int g = 0; g < gap; g++) idle();
    end
  endtask

  initial begin
    reset      = 1'b1;
    char       = 8'h00;
    char_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_word", word, 32'h0);
    chk("rst_digits", 32'(digits), 32'd0);
    chk("rst_wv", 32'(word_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // 1: "0x1f;" streamed continuously.
    wv_pulses = 0; err_pulses = 0;
    send("0x1f", 0);
    drive(";");
    chk("t1_busy_before_semi", 32'(busy), 32'd1);
    idle();
    chk("t1_wv", 32'(word_valid), 32'd1);
    chk("t1_word", word, 32'h0000001f);
    chk("t1_digits", 32'(digits), 32'd2);
    chk("t1_busy", 32'(busy), 32'd0);
    idle();
    chk("t1_wv_drop", 32'(word_valid), 32'd0);
    chk("t1_wv_count", 32'(wv_pulses), 32'd1);
    chk("t1_err_count", 32'(err_pulses), 32'd0);

    // 2: "0xdeadbeef;" with two idle cycles between characters.
    wv_pulses = 0; err_pulses = 0;
    send("0xdeadbeef;", 2);
    chk("t2_word", word, 32'hdeadbeef);
    chk("t2_digits", 32'(digits), 32'd8);
    repeat (3) idle();
    chk("t2_wv_count", 32'(wv_pulses), 32'd1);
    chk("t2_err_count", 32'(err_pulses), 32'd0);

    // 3: nine digits overflow; err follows the ninth digit.
    wv_pulses = 0; err_pulses = 0;
    send("0x12345678", 0);
    drive("9");
    chk("t3_no_err_before", 32'(err), 32'd0);
    drive(";");
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_busy_in_err", 32'(busy), 32'd1);
    idle();
    chk("t3_err_drop", 32'(err), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_word", word, 32'hdeadbeef);
    repeat (2) idle();
    chk("t3_err_count", 32'(err_pulses), 32'd1);
    chk("t3_wv_count", 32'(wv_pulses), 32'd0);

    // 4: malformed tokens. The "0x5;" after "0x;" is swallowed in the
    // error state because "0x;" only reaches ERR on its ';'.
    wv_pulses = 0; err_pulses = 0;
    send("0xAB;", 0);
    idle();
    chk("t4_ab_word", word, 32'hdeadbeef);
    chk("t4_ab_err_count", 32'(err_pulses), 32'd1);
    send("0x5;", 0);
    send("0x;", 0);
    send("0x5;", 0);
    send("07;", 0);
    send("0x5;", 0);
    idle();
    chk("t4_word", word, 32'h00000005);
    chk("t4_digits", 32'(digits), 32'd1);
    repeat (2) idle();
    chk("t4_err_count", 32'(err_pulses), 32'd3);
    chk("t4_wv_count", 32'(wv_pulses), 32'd2);
    chk("t4_busy", 32'(busy), 32'd0);

    // 5: leading noise, then back-to-back tokens.
    wv_pulses = 0; err_pulses = 0;
    send(" \n0xa;", 0);
    drive("0");
    chk("t5_wv_a", 32'(word_valid), 32'd1);
    chk("t5_word_a", word, 32'h0000000a);
    send("xb;", 0);
    idle();
    chk("t5_wv_b", 32'(word_valid), 32'd1);
    chk("t5_word_b", word, 32'h0000000b);
    repeat (2) idle();
    chk("t5_wv_count", 32'(wv_pulses), 32'd2);
    chk("t5_err_count", 32'(err_pulses), 32'd0);

    // 6: reset in the middle of a token.
    wv_pulses = 0; err_pulses = 0;
    send("0x12", 0);
    @(negedge clk);
    reset      = 1'b1;
    char_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_rst_word", word, 32'h0);
    chk("t6_rst_digits", 32'(digits), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    send("3;0x7;", 0);
    idle();
    chk("t6_wv", 32'(word_valid), 32'd1);
    chk("t6_word", word, 32'h00000007);
    chk("t6_digits", 32'(digits), 32'd1);
    repeat (2) idle();
    chk("t6_err_count", 32'(err_pulses), 32'd0);
    chk("t6_wv_count", 32'(wv_pulses), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
